// File: rtl/life_row_engine.sv
// life_row_engine: streaming Game of Life (B3/S23) row engine, one cell in and
// one cell out per handshake, three row buffers sliding down the grid.
module life_row_engine #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   output logic out_valid,
   output logic out_bit,
   input  logic out_ready,
   output logic out_last
);
   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   typedef enum logic [1:0] {LOAD, EMIT, FLUSH} state_t;
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_prv, r_cur, r_nxt, w_nxt_wr, w_s_row;
   logic [CW-1:0]    r_col;
   logic [RW-1:0]    r_row;
   logic             w_in_xfer, w_out_xfer, w_col_end, w_row_end, w_self;
   logic [WIDTH+1:0] w_n_sh, w_c_sh, w_s_sh;
   logic [7:0]       w_nb;
   logic [3:0]       w_cnt;

   assign w_col_end  = r_col == CW'(WIDTH - 1);
   assign w_row_end  = r_row == RW'(HEIGHT - 1);
   assign in_ready   = r_state == LOAD;
   assign out_valid  = r_state != LOAD;
   assign out_last   = (r_state == FLUSH) && w_col_end;
   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = out_valid & out_ready;
   // Zero-padded rows shifted so the current column's 3-cell window sits at [2:0]
   assign w_s_row = (r_state == FLUSH) ? {WIDTH{1'b0}} : r_nxt;
   assign w_n_sh  = {1'b0, r_prv, 1'b0} >> r_col;
   assign w_c_sh  = {1'b0, r_cur, 1'b0} >> r_col;
   assign w_s_sh  = {1'b0, w_s_row, 1'b0} >> r_col;
   assign w_nb    = {w_s_sh[2:0], w_c_sh[2], w_c_sh[0], w_n_sh[2:0]};
   assign w_self  = w_c_sh[1];
   assign out_bit = out_valid & ((w_cnt == 4'd3) | (w_self & (w_cnt == 4'd2)));

   always_comb begin
      w_cnt = 4'd0;
      for (int i = 0; i < 8; i++) w_cnt = w_cnt + {3'b000, w_nb[i]};
   end

   always_comb begin
      w_nxt_wr        = r_nxt;
      w_nxt_wr[r_col] = in_bit;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         LOAD:    if (w_in_xfer && w_col_end && r_row != '0) w_state_nxt = EMIT;
         EMIT:    if (w_out_xfer && w_col_end) w_state_nxt = w_row_end ? FLUSH : LOAD;
         FLUSH:   if (w_out_xfer && w_col_end) w_state_nxt = LOAD;
         default: w_state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prv <= '0;
         r_cur <= '0;
         r_nxt <= '0;
         r_col <= '0;
         r_row <= '0;
      end else if (w_in_xfer) begin
         r_nxt <= w_nxt_wr;
         r_col <= w_col_end ? '0 : r_col + 1'b1;
         if (w_col_end && r_row == '0) begin
            r_prv <= '0;
            r_cur <= w_nxt_wr;
            r_row <= RW'(1);
         end
      end else if (w_out_xfer) begin
         r_col <= w_col_end ? '0 : r_col + 1'b1;
         if (w_col_end && r_state == FLUSH) begin
            r_prv <= '0;
            r_cur <= '0;
            r_nxt <= '0;
            r_row <= '0;
         end else if (w_col_end) begin
            r_prv <= r_cur;
            r_cur <= r_nxt;
            if (!w_row_end) r_row <= r_row + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_life_row_engine.sv
// tb_life_row_engine: directed 5x5 Life vectors with hand-computed results.
module tb_life_row_engine;
   localparam int W = 5;
   localparam int H = 5;
   localparam logic [24:0] BLINK_IN  = 25'h0021080;
   localparam logic [24:0] BLINK_OUT = 25'h0003800;
   localparam logic [24:0] BLOCK     = 25'h00018C0;
   localparam logic [24:0] ONES      = 25'h1FFFFFF;
   localparam logic [24:0] CORNERS   = 25'h1100011;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_bit, out_last;
   int   cmp = 0, err = 0;

   always #5 clk = ~clk;

   life_row_engine #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready), .out_last(out_last)
   );

   // Streams grid g in raster order and collects outputs (bit 0 = first cell).
   task automatic run_gen(input logic [24:0] g, input bit stall, input int abort_at,
                          output logic [24:0] o, output int lasts, output bit last_ok,
                          output int stall_err, output int first_in, output int both_err,
                          output bit tmo);
      logic [24:0] gs;
      int ic, oc, cyc;
      logic held_v, held_b, held_l;
      gs = g; ic = 0; oc = 0; cyc = 0; held_v = 1'b0; held_b = 1'b0; held_l = 1'b0;
      o = '0; lasts = 0; last_ok = 1'b1; stall_err = 0; first_in = -1; both_err = 0; tmo = 1'b0;
      while (oc < 25 && !(abort_at > 0 && oc >= abort_at) && cyc < 1000) begin
         @(negedge clk);
         in_valid  = ic < 25;
         in_bit    = (ic < 25) ? gs[0] : 1'b0;
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (in_ready && out_valid) both_err++;
         if (held_v && (out_bit !== held_b || out_last !== held_l)) stall_err++;
         if (out_valid && first_in < 0) first_in = ic;
         if (in_valid && in_ready) begin
            ic++;
            gs = gs >> 1;
         end
         if (out_valid && out_ready) begin
            o = {out_bit, o[24:1]};
            if (out_last) begin
               lasts++;
               if (oc != 24) last_ok = 1'b0;
            end
            oc++;
         end
         held_v = out_valid && !out_ready;
         held_b = out_bit;
         held_l = out_last;
         cyc++;
         @(posedge clk);
      end
      tmo = cyc >= 1000;
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      cmp++; if (out_last !== 1'b0)  begin err++; $display("FAIL rst_out_last got %b want 0", out_last); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL rel_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_blinker();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      run_gen(BLINK_IN, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (t !== 1'b0)      begin err++; $display("FAIL blink_timeout got %b want 0", t); end
      cmp++; if (o !== BLINK_OUT) begin err++; $display("FAIL blink_out got %h want %h", o, BLINK_OUT); end
      cmp++; if (l !== 1)         begin err++; $display("FAIL blink_lasts got %0d want 1", l); end
      cmp++; if (lok !== 1'b1)    begin err++; $display("FAIL blink_last_pos got %b want 1", lok); end
      cmp++; if (fi !== 10)       begin err++; $display("FAIL blink_latency got %0d want 10", fi); end
      cmp++; if (be !== 0)        begin err++; $display("FAIL blink_both_ready got %0d want 0", be); end
   endtask

   task automatic test_block_zero();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      run_gen(BLOCK, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== BLOCK)  begin err++; $display("FAIL block_out got %h want %h", o, BLOCK); end
      cmp++; if (l !== 1)      begin err++; $display("FAIL block_lasts got %0d want 1", l); end
      run_gen('0, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== 25'h0)  begin err++; $display("FAIL zero_out got %h want 0", o); end
      cmp++; if (t !== 1'b0)   begin err++; $display("FAIL zero_timeout got %b want 0", t); end
   endtask

   task automatic test_all_ones();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      run_gen(ONES, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== CORNERS) begin err++; $display("FAIL ones_out got %h want %h", o, CORNERS); end
      cmp++; if (lok !== 1'b1)  begin err++; $display("FAIL ones_last_pos got %b want 1", lok); end
      run_gen('0, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== 25'h0)   begin err++; $display("FAIL ones_then_zero got %h want 0", o); end
   endtask

   task automatic test_stall();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      for (int k = 0; k < 2; k++) begin
         run_gen(BLINK_IN, 1'b1, 0, o, l, lok, se, fi, be, t);
         cmp++; if (t !== 1'b0)      begin err++; $display("FAIL stall_timeout got %b want 0", t); end
         cmp++; if (o !== BLINK_OUT) begin err++; $display("FAIL stall_out got %h want %h", o, BLINK_OUT); end
         cmp++; if (se !== 0)        begin err++; $display("FAIL stall_hold got %0d changes want 0", se); end
         cmp++; if (l !== 1)         begin err++; $display("FAIL stall_lasts got %0d want 1", l); end
         cmp++; if (be !== 0)        begin err++; $display("FAIL stall_both_ready got %0d want 0", be); end
      end
   endtask

   task automatic test_reset_mid_emit();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      run_gen(ONES, 1'b0, 12, o, l, lok, se, fi, be, t);
      cmp++; if (out_valid !== 1'b1) begin err++; $display("FAIL abort_in_emit got %b want 1", out_valid); end
      #1;
      rst_n = 1'b0;
      #1;
      cmp++; if (in_ready !== 1'b1)  begin err++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
      cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      run_gen(BLINK_IN, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== BLINK_OUT) begin err++; $display("FAIL abort_blink_out got %h want %h", o, BLINK_OUT); end
      cmp++; if (fi !== 10)       begin err++; $display("FAIL abort_latency got %0d want 10", fi); end
   endtask

   task automatic test_back_to_back();
      logic [24:0] o; int l, se, fi, be; bit lok, t;
      run_gen(BLINK_IN, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== BLINK_OUT) begin err++; $display("FAIL b2b_blink got %h want %h", o, BLINK_OUT); end
      run_gen(BLOCK, 1'b0, 0, o, l, lok, se, fi, be, t);
      cmp++; if (o !== BLOCK)     begin err++; $display("FAIL b2b_block got %h want %h", o, BLOCK); end
      cmp++; if (l !== 1)         begin err++; $display("FAIL b2b_lasts got %0d want 1", l); end
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_block_zero();
      test_all_ones();
      test_stall();
      test_reset_mid_emit();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
